// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//
// Shared definitions for the VGA raster logic.
//   - coord_t         : 10-bit unsigned screen coordinate (hCount / vCount).
//   - DEF_H_* / DEF_V_*: default 640x480@60 timing, expressed as counter values
//                       where count 0 is the start of the sync pulse.
//   - SCREEN_*        : visible-region bounds used by the renderer and game
//                       logic to convert raster counts into pixel positions.
//   - in_span()       : half-open range test used for the visible window.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Horizontal timing, in pixels. Count 0 is the start of hSync.
    localparam int DEF_H_TOTAL     = 800;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_VIS_START = 144;
    localparam int DEF_H_VIS_END   = 784;

    // Vertical timing, in lines. Count 0 is the start of vSync.
    localparam int DEF_V_TOTAL     = 525;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_VIS_START = 35;
    localparam int DEF_V_VIS_END   = 515;

    // Renderer-facing bounds. SCREEN_LEFT / SCREEN_TOP are the counts just
    // before the first visible column / line, so pixel x = hCount - SCREEN_LEFT
    // runs 1..640; sprite code was written against that origin.
    localparam int SCREEN_LEFT   = 143;
    localparam int SCREEN_TOP    = 34;
    localparam int SCREEN_WIDTH  = DEF_H_VIS_END - DEF_H_VIS_START;
    localparam int SCREEN_HEIGHT = DEF_V_VIS_END - DEF_V_VIS_START;

    // True when lo <= c < hi. Done in int so that an upper bound of 1024
    // (a legal H_TOTAL/V_TOTAL) does not wrap in 10 bits.
    function automatic logic in_span(input coord_t c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// -----------------------------------------------------------------------------
// sync_delay
//
// DEPTH-stage shift register for the {hSync, vSync} pair, clocked every clk so
// the sync outputs line up with the renderer's registered RGB path. DEPTH = 0
// degenerates into a wire.
//
// Ports:
//   clk   in  1 : system clock
//   rst   in  1 : asynchronous active-high reset, clears every stage to 0
//   din   in  2 : {hSync, vSync} aligned with the counters
//   dout  out 2 : din delayed by DEPTH clk cycles
// -----------------------------------------------------------------------------
module sync_delay #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            // No registers in this configuration; clk/rst are intentionally idle.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign dout = din;
        end else begin : g_shift
            logic [1:0] stage_reg [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_reg[i] <= 2'b00;
                    end
                end else begin
                    stage_reg[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// 640x480@60 raster timing from the 100 MHz system clock. A clk/DIV pixel
// enable steps a horizontal and a vertical counter; sync, blanking and frame
// strobes are registered from the *next* counter values so they are always
// consistent with hCount/vCount in the same clk cycle.
//
// Ports:
//   clk          in  1  : system clock (100 MHz)
//   rst          in  1  : asynchronous active-high reset
//   pix_en       out 1  : one-clk pulse per pixel period
//   hCount       out 10 : current column, 0..H_TOTAL-1
//   vCount       out 10 : current line, 0..V_TOTAL-1
//   bright       out 1  : current position lies in the visible window
//   hSync        out 1  : active-low horizontal sync, aligned to hCount
//   vSync        out 1  : active-low vertical sync, aligned to vCount
//   hSync_d      out 1  : hSync delayed by PIPE_DELAY clk cycles
//   vSync_d      out 1  : vSync delayed by PIPE_DELAY clk cycles
//   frame_start  out 1  : one-clk pulse as the counters become (0,0)
//   vblank_start out 1  : one-clk pulse as the counters become (0,V_VIS_END)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int DIV         = 4,
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_VIS_START = DEF_H_VIS_START,
    parameter int H_VIS_END   = DEF_H_VIS_END,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_VIS_START = DEF_V_VIS_START,
    parameter int V_VIS_END   = DEF_V_VIS_END,
    parameter int PIPE_DELAY  = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       hSync_d,
    output logic       vSync_d,
    output logic       frame_start,
    output logic       vblank_start
);

    // A 1-bit divider is kept for DIV = 1 so the counter never has zero width;
    // it simply sits at 0 and the terminal-count decode is always true.
    localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam coord_t          H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t          V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t          V_BLANK  = coord_t'(V_VIS_END);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_next;
    logic             pix_en_reg;

    coord_t h_reg, h_next;
    coord_t v_reg, v_next;

    logic hsync_reg, hsync_next;
    logic vsync_reg, vsync_next;
    logic bright_reg, bright_next;
    logic frame_start_reg, frame_start_next;
    logic vblank_start_reg, vblank_start_next;

    // ------------------------------------------------------------------
    // Pixel divider
    // ------------------------------------------------------------------
    // pix_en is a registered decode of the divider's next value, so it is
    // high exactly while div_cnt sits at DIV-1 and is guaranteed 0 in reset
    // (a plain combinational decode would be stuck high for DIV = 1).
    always_comb begin
        div_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DIV_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            pix_en_reg  <= 1'b0;
        end else begin
            div_cnt_reg <= div_next;
            pix_en_reg  <= (div_next == DIV_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    // Wrap by explicit compare so any H_TOTAL/V_TOTAL up to 1024 works.
    always_comb begin
        h_next = h_reg;
        v_next = v_reg;
        if (pix_en_reg) begin
            if (h_reg == H_LAST) begin
                h_next = '0;
                v_next = (v_reg == V_LAST) ? '0 : v_reg + coord_t'(1);
            end else begin
                h_next = h_reg + coord_t'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Derived outputs, computed from the next counter values
    // ------------------------------------------------------------------
    // Strobes require pix_en so they fire only on the step into the target
    // position, never while the counters are merely holding there (and never
    // on reset, even though reset also leaves the counters at (0,0)).
    always_comb begin
        hsync_next        = ~in_span(h_next, 0, H_SYNC);
        vsync_next        = ~in_span(v_next, 0, V_SYNC);
        bright_next       = in_span(h_next, H_VIS_START, H_VIS_END) &&
                            in_span(v_next, V_VIS_START, V_VIS_END);
        frame_start_next  = pix_en_reg && (h_next == '0) && (v_next == '0);
        vblank_start_next = pix_en_reg && (h_next == '0) && (v_next == V_BLANK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_reg            <= '0;
            v_reg            <= '0;
            hsync_reg        <= 1'b0;
            vsync_reg        <= 1'b0;
            bright_reg       <= 1'b0;
            frame_start_reg  <= 1'b0;
            vblank_start_reg <= 1'b0;
        end else begin
            h_reg            <= h_next;
            v_reg            <= v_next;
            hsync_reg        <= hsync_next;
            vsync_reg        <= vsync_next;
            bright_reg       <= bright_next;
            frame_start_reg  <= frame_start_next;
            vblank_start_reg <= vblank_start_next;
        end
    end

    // ------------------------------------------------------------------
    // Sync delay line matching the renderer's ROM + RGB register latency
    // ------------------------------------------------------------------
    sync_delay #(
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({hsync_reg, vsync_reg}),
        .dout ({hSync_d, vSync_d})
    );

    assign pix_en       = pix_en_reg;
    assign hCount       = h_reg;
    assign vCount       = v_reg;
    assign bright       = bright_reg;
    assign hSync        = hsync_reg;
    assign vSync        = vsync_reg;
    assign frame_start  = frame_start_reg;
    assign vblank_start = vblank_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share clk/rst:
//   u_a : DIV=4, full 800-pixel line, shortened 10-line frame
//         (vSync lines 0..1, visible lines 3..7), PIPE_DELAY=2.
//   u_b : DIV=1, full 800-pixel line, 4-line frame, PIPE_DELAY=0.
// The short frame keeps a whole frame (10 x 3200 = 32000 clk) affordable.
// Outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic       a_pix_en, a_bright, a_hsync, a_vsync, a_hsync_d, a_vsync_d;
    logic       a_frame_start, a_vblank_start;
    logic [9:0] a_h, a_v;

    logic       b_pix_en, b_bright, b_hsync, b_vsync, b_hsync_d, b_vsync_d;
    logic       b_frame_start, b_vblank_start;
    logic [9:0] b_h, b_v;

    vga_timing_gen #(
        .DIV(4), .H_TOTAL(800), .H_SYNC(96), .H_VIS_START(144), .H_VIS_END(784),
        .V_TOTAL(10), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(8), .PIPE_DELAY(2)
    ) u_a (
        .clk(clk), .rst(rst), .pix_en(a_pix_en), .hCount(a_h), .vCount(a_v),
        .bright(a_bright), .hSync(a_hsync), .vSync(a_vsync),
        .hSync_d(a_hsync_d), .vSync_d(a_vsync_d),
        .frame_start(a_frame_start), .vblank_start(a_vblank_start)
    );

    vga_timing_gen #(
        .DIV(1), .H_TOTAL(800), .H_SYNC(96), .H_VIS_START(144), .H_VIS_END(784),
        .V_TOTAL(4), .V_SYNC(1), .V_VIS_START(1), .V_VIS_END(3), .PIPE_DELAY(0)
    ) u_b (
        .clk(clk), .rst(rst), .pix_en(b_pix_en), .hCount(b_h), .vCount(b_v),
        .bright(b_bright), .hSync(b_hsync), .vSync(b_vsync),
        .hSync_d(b_hsync_d), .vSync_d(b_vsync_d),
        .frame_start(b_frame_start), .vblank_start(b_vblank_start)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input longint actual, input longint expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int     found;
        int     hs_h1, hs_h2, vs_h1, vs_h2;
        int     prev_h, prev_v, prev_bright, b_prev_h;
        int     fs_first, fs_cnt, vb_cnt;
        int     hs_low4, br_line4, br_rise_h, br_fall_h;
        int     br_outside, br_total, vs_err, dly_err;
        int     b_pix_zero, b_dly_err, b_wrap1, b_wrap2;

        // ---------------- power-on reset ----------------
        rst = 1'b1;
        repeat (3) tick();
        check_val("rst_hcount",  a_h, 0);
        check_val("rst_vcount",  a_v, 0);
        check_val("rst_hsync",   a_hsync, 0);
        check_val("rst_vsync",   a_vsync, 0);
        check_val("rst_bright",  a_bright, 0);
        check_val("rst_pix_en",  a_pix_en, 0);
        check_val("rst_fs",      a_frame_start, 0);
        check_val("rst_hsync_d", a_hsync_d, 0);
        check_val("rst_b_pix_en", b_pix_en, 0);
        rst = 1'b0;

        // ---------------- run to (500,5), then reset asynchronously ----------------
        found = 0;
        for (int k = 0; k < 20000 && found == 0; k++) begin
            tick();
            if (a_h == 10'd500 && a_v == 10'd5) found = 1;
        end
        check_val("reach_mid_frame", found, 1);
        check_val("pre_rst_bright", a_bright, 1);
        check_val("pre_rst_hsync_d", a_hsync_d, 1);
        #3 rst = 1'b1;
        #1;
        check_val("async_hcount",  a_h, 0);
        check_val("async_vcount",  a_v, 0);
        check_val("async_hsync",   a_hsync, 0);
        check_val("async_vsync",   a_vsync, 0);
        check_val("async_bright",  a_bright, 0);
        check_val("async_hsync_d", a_hsync_d, 0);
        repeat (2) tick();
        rst = 1'b0;

        // ---------------- one full frame + a bit, monitored every clk ----------------
        hs_h1 = 0; hs_h2 = 0; vs_h1 = 0; vs_h2 = 0;
        prev_h = 0; prev_v = 0; prev_bright = 0; b_prev_h = 0;
        fs_first = -1; fs_cnt = 0; vb_cnt = 0;
        hs_low4 = 0; br_line4 = 0; br_rise_h = -1; br_fall_h = -1;
        br_outside = 0; br_total = 0; vs_err = 0; dly_err = 0;
        b_pix_zero = 0; b_dly_err = 0; b_wrap1 = -1; b_wrap2 = -1;

        for (int k = 1; k <= 33000; k++) begin
            hs_h2 = hs_h1; hs_h1 = int'(a_hsync);
            vs_h2 = vs_h1; vs_h1 = int'(a_vsync);
            tick();

            if (k == 1) check_val("pix_en_edge1", a_pix_en, 0);
            if (k == 3) begin
                check_val("pix_en_before_edge4", a_pix_en, 1);
                check_val("hcount_before_edge4", a_h, 0);
            end
            if (k == 4) check_val("hcount_after_edge4", a_h, 1);

            if (a_frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
            end
            if (a_vblank_start) vb_cnt++;

            if (prev_h == 799 && a_h == 10'd0) begin
                if (prev_v == 4) check_val("wrap_vinc", a_v, 5);
                if (prev_v == 7) check_val("vblank_at_515_equiv", a_vblank_start, 1);
                if (prev_v == 9) begin
                    check_val("frame_wrap_v", a_v, 0);
                    check_val("frame_wrap_fs", a_frame_start, 1);
                end
            end

            if (a_v == 10'd4) begin
                if (!a_hsync) hs_low4++;
                if (a_bright) br_line4++;
                if (a_bright && prev_bright == 0 && prev_v == 4) br_rise_h = int'(a_h);
                if (!a_bright && prev_bright == 1 && prev_v == 4) br_fall_h = int'(a_h);
            end
            if (a_bright) br_total++;
            if (a_bright && (a_v < 10'd3 || a_v >= 10'd8)) br_outside++;
            if (a_vsync != (a_v >= 10'd2)) vs_err++;
            if (int'(a_hsync_d) != hs_h2 || int'(a_vsync_d) != vs_h2) dly_err++;

            if (!b_pix_en) b_pix_zero++;
            if (b_hsync_d != b_hsync || b_vsync_d != b_vsync) b_dly_err++;
            if (b_prev_h == 799 && b_h == 10'd0) begin
                if (b_wrap1 < 0) b_wrap1 = k;
                else if (b_wrap2 < 0) b_wrap2 = k;
            end

            prev_h = int'(a_h); prev_v = int'(a_v); prev_bright = int'(a_bright);
            b_prev_h = int'(b_h);
        end

        check_val("frame_start_edge", fs_first, 32000);
        check_val("frame_start_count", fs_cnt, 1);
        check_val("vblank_count", vb_cnt, 1);
        check_val("hsync_low_cycles", hs_low4, 384);
        check_val("bright_line_cycles", br_line4, 2560);
        check_val("bright_rise_h", br_rise_h, 144);
        check_val("bright_fall_h", br_fall_h, 784);
        check_val("bright_frame_cycles", br_total, 12800);
        check_val("bright_blank_lines", br_outside, 0);
        check_val("vsync_vs_vcount", vs_err, 0);
        check_val("delay2_align", dly_err, 0);
        check_val("div1_pix_en_gaps", b_pix_zero, 0);
        check_val("div1_first_wrap", b_wrap1, 801);
        check_val("div1_line_period", b_wrap2 - b_wrap1, 800);
        check_val("delay0_passthru", b_dly_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
